// File: rtl/rps_match_engine.sv
// Best-of-N stone/paper/scissors match controller.
// It scores one handshaked move pair per round and declares a match winner.
module rps_match_engine #(
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 9,
    parameter int SCORE_W    = 4,
    parameter int RND_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [1:0]         p1_move,
    input  logic [1:0]         p2_move,
    input  logic               move_valid,
    output logic               move_ready,
    input  logic               new_match,
    output logic               round_valid,
    output logic [1:0]         round_result,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [RND_W-1:0]   round_count,
    output logic [3:0]         last_moves,
    output logic               match_done,
    output logic [1:0]         match_winner
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] RES_TIE = 2'b00;
    localparam logic [1:0] RES_P1  = 2'b01;
    localparam logic [1:0] RES_P2  = 2'b10;
    localparam logic [1:0] RES_INV = 2'b11;

    localparam logic [SCORE_W-1:0] WIN_T = SCORE_W'(WIN_TARGET);
    localparam logic [RND_W-1:0]   MAX_R = RND_W'(MAX_ROUNDS);

    logic [1:0]         state;
    logic               handshake;
    logic [1:0]         eval_p1;
    logic [1:0]         eval_p2;
    logic [1:0]         eval_result;
    logic [SCORE_W-1:0] p1_next;
    logic [SCORE_W-1:0] p2_next;
    logic [RND_W-1:0]   rc_next;
    logic               eval_done;
    logic [1:0]         final_winner;

    assign move_ready = rst_n & ena & (state == IDLE);
    assign handshake  = move_valid & move_ready;

    // The round is judged from the latched pair, so EVAL never depends on live inputs.
    always_comb begin
        eval_p1     = last_moves[3:2];
        eval_p2     = last_moves[1:0];
        eval_result = RES_P2;
        if (eval_p1 == 2'b11 || eval_p2 == 2'b11)
            eval_result = RES_INV;
        else if (eval_p1 == eval_p2)
            eval_result = RES_TIE;
        else if ((eval_p1 == 2'b00 && eval_p2 == 2'b10) ||
                 (eval_p1 == 2'b01 && eval_p2 == 2'b00) ||
                 (eval_p1 == 2'b10 && eval_p2 == 2'b01))
            eval_result = RES_P1;

        p1_next = p1_score + {{(SCORE_W-1){1'b0}}, (eval_result == RES_P1)};
        p2_next = p2_score + {{(SCORE_W-1){1'b0}}, (eval_result == RES_P2)};
        rc_next = round_count + {{(RND_W-1){1'b0}}, (eval_result != RES_INV)};

        eval_done = (p1_next == WIN_T) || (p2_next == WIN_T) || (rc_next == MAX_R);

        // A player at the target outranks the score comparison used on round-limit exit.
        final_winner = 2'b00;
        if (p1_next == WIN_T)
            final_winner = 2'b01;
        else if (p2_next == WIN_T)
            final_winner = 2'b10;
        else if (p1_next > p2_next)
            final_winner = 2'b01;
        else if (p2_next > p1_next)
            final_winner = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            round_valid  <= 1'b0;
            round_result <= '0;
            p1_score     <= '0;
            p2_score     <= '0;
            round_count  <= '0;
            last_moves   <= '0;
            match_done   <= 1'b0;
            match_winner <= '0;
        end else if (ena) begin
            if (new_match) begin
                // last_moves is deliberately kept across a match clear.
                state        <= IDLE;
                round_valid  <= 1'b0;
                round_result <= '0;
                p1_score     <= '0;
                p2_score     <= '0;
                round_count  <= '0;
                match_done   <= 1'b0;
                match_winner <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        round_valid <= 1'b0;
                        if (handshake) begin
                            last_moves <= {p1_move, p2_move};
                            state      <= EVAL;
                        end
                    end
                    EVAL: begin
                        round_valid  <= 1'b1;
                        round_result <= eval_result;
                        p1_score     <= p1_next;
                        p2_score     <= p2_next;
                        round_count  <= rc_next;
                        if (eval_done) begin
                            state        <= DONE;
                            match_done   <= 1'b1;
                            match_winner <= final_winner;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    DONE: begin
                        round_valid <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rps_match_engine.sv
// Self-checking bench for rps_match_engine: a move-level model pushes expected
// round outcomes to a scoreboard queue that each scenario pops on round_valid.
module tb_rps_match_engine;

    localparam int WIN_TARGET = 3;
    localparam int MAX_ROUNDS = 9;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [1:0] p1_move;
    logic [1:0] p2_move;
    logic       move_valid;
    logic       move_ready;
    logic       new_match;
    logic       round_valid;
    logic [1:0] round_result;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [3:0] round_count;
    logic [3:0] last_moves;
    logic       match_done;
    logic [1:0] match_winner;

    typedef struct packed {
        logic        ok;
        logic [16:0] outcome;
        logic [3:0]  lm;
        logic        ready_mid;
        logic [7:0]  wait_cycles;
    } obs_t;

    int checks = 0;
    int errors = 0;

    logic [16:0] sb[$];
    int m1, m2, mrc, mwin;
    bit mdone;

    rps_match_engine #(
        .WIN_TARGET(WIN_TARGET),
        .MAX_ROUNDS(MAX_ROUNDS),
        .SCORE_W(4),
        .RND_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .p1_move(p1_move),
        .p2_move(p2_move),
        .move_valid(move_valid),
        .move_ready(move_ready),
        .new_match(new_match),
        .round_valid(round_valid),
        .round_result(round_result),
        .p1_score(p1_score),
        .p2_score(p2_score),
        .round_count(round_count),
        .last_moves(last_moves),
        .match_done(match_done),
        .match_winner(match_winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Modular form of the rules: (p1 - p2) mod 3 == 1 means p1 wins.
    function automatic int judge(input int a, input int b);
        int d;
        if (a == 3 || b == 3) return 3;
        d = (a + 3 - b) % 3;
        return d;
    endfunction

    task automatic model_push(input int a, input int b);
        int r;
        r = judge(a, b);
        if (r == 1) m1++;
        if (r == 2) m2++;
        if (r != 3) mrc++;
        if (m1 == WIN_TARGET) begin
            mdone = 1; mwin = 1;
        end else if (m2 == WIN_TARGET) begin
            mdone = 1; mwin = 2;
        end else if (mrc == MAX_ROUNDS) begin
            mdone = 1;
            mwin = (m1 > m2) ? 1 : (m2 > m1) ? 2 : 0;
        end
        sb.push_back({2'(r), 4'(m1), 4'(m2), 4'(mrc), mdone, 2'(mwin)});
    endtask

    function automatic logic [16:0] sb_pop();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    function automatic logic [16:0] dut_outcome();
        return {round_result, p1_score, p2_score, round_count, match_done, match_winner};
    endfunction

    task automatic pulse_new_match();
        @(negedge clk);
        new_match = 1'b1;
        @(negedge clk);
        new_match = 1'b0;
        m1 = 0; m2 = 0; mrc = 0; mwin = 0; mdone = 0;
        sb.delete();
    endtask

    // Drives one handshake (called at a negedge) and returns at the negedge where round_valid is seen.
    task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b, output obs_t o);
        int n;
        o = '0;
        p1_move = a;
        p2_move = b;
        move_valid = 1'b1;
        n = 0;
        while (move_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        o.wait_cycles = 8'(n);
        if (n >= 20) begin
            move_valid = 1'b0;
            return;
        end
        model_push(int'(a), int'(b));
        @(negedge clk);
        move_valid = 1'b0;
        o.ready_mid = move_ready;
        n = 0;
        while (round_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) return;
        o.ok = 1'b1;
        o.outcome = dut_outcome();
        o.lm = last_moves;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            p1_move = 2'($urandom);
            p2_move = 2'($urandom);
            move_valid = 1'($urandom);
            new_match = 1'($urandom);
            ena = 1'($urandom);
        end
        @(negedge clk);
        checks++;
        if ({round_valid, dut_outcome(), last_moves} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_regs got %h exp 0", {round_valid, dut_outcome(), last_moves});
        end
        checks++;
        if (move_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready_low got %b exp 0", move_ready);
        end
        rst_n = 1'b1; ena = 1'b1; move_valid = 1'b0; new_match = 1'b0;
        p1_move = 2'b00; p2_move = 2'b00;
        @(negedge clk);
        checks++;
        if (move_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready got %b exp 1", move_ready);
        end
    endtask

    task automatic test_single_round();
        obs_t o;
        logic [16:0] e;
        applyStimulus(2'b00, 2'b10, o);
        e = sb_pop();
        checks++;
        if (o.ok !== 1'b1 || o.outcome !== e) begin
            errors++;
            $display("[TB] FAIL single_outcome got %h ok=%b exp %h", o.outcome, o.ok, e);
        end
        checks++;
        if (o.lm !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL single_last_moves got %b exp 0010", o.lm);
        end
        checks++;
        if (o.ready_mid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ready_eval got %b exp 0", o.ready_mid);
        end
        @(negedge clk);
        checks++;
        if (round_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_pulse got %b exp 0", round_valid);
        end
    endtask

    task automatic test_invalid();
        obs_t o;
        logic [16:0] e;
        applyStimulus(2'b11, 2'b00, o);
        e = sb_pop();
        checks++;
        if (o.ok !== 1'b1 || o.outcome !== e) begin
            errors++;
            $display("[TB] FAIL invalid_outcome got %h ok=%b exp %h", o.outcome, o.ok, e);
        end
        checks++;
        if (move_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL invalid_idle got %b exp 1", move_ready);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        logic [16:0] e;
        bit saw_valid;
        pulse_new_match();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b00, 2'b01, o);
            e = sb_pop();
            checks++;
            if (o.ok !== 1'b1 || o.outcome !== e) begin
                errors++;
                $display("[TB] FAIL b2b_round%0d got %h ok=%b exp %h", i, o.outcome, o.ok, e);
            end
            if (i > 0) begin
                checks++;
                if (o.wait_cycles !== 8'd0) begin
                    errors++;
                    $display("[TB] FAIL b2b_stall%0d got %0d exp 0", i, o.wait_cycles);
                end
            end
        end
        checks++;
        if (move_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_ready_done got %b exp 0", move_ready);
        end
        p1_move = 2'b00; p2_move = 2'b10; move_valid = 1'b1;
        saw_valid = 0;
        repeat (4) begin
            @(negedge clk);
            if (round_valid === 1'b1) saw_valid = 1;
        end
        move_valid = 1'b0;
        checks++;
        if (saw_valid || {p2_score, match_done, match_winner, last_moves} !== {4'd3, 1'b1, 2'b10, 4'b0001}) begin
            errors++;
            $display("[TB] FAIL done_ignores_move got rv=%b %h exp rv=0 %h", saw_valid,
                     {p2_score, match_done, match_winner, last_moves}, {4'd3, 1'b1, 2'b10, 4'b0001});
        end
        pulse_new_match();
        checks++;
        if ({round_valid, dut_outcome()} !== 18'd0 || move_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL new_match_clear got %h ready=%b exp 0 ready=1", {round_valid, dut_outcome()}, move_ready);
        end
        checks++;
        if (last_moves !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL new_match_keeps_moves got %b exp 0001", last_moves);
        end
    endtask

    task automatic test_ties();
        obs_t o;
        logic [16:0] e;
        pulse_new_match();
        for (int i = 0; i < MAX_ROUNDS; i++) begin
            applyStimulus(2'b01, 2'b01, o);
            e = sb_pop();
            checks++;
            if (o.ok !== 1'b1 || o.outcome !== e) begin
                errors++;
                $display("[TB] FAIL tie_round%0d got %h ok=%b exp %h", i, o.outcome, o.ok, e);
            end
        end
        checks++;
        if ({match_done, match_winner, round_count} !== {1'b1, 2'b00, 4'd9}) begin
            errors++;
            $display("[TB] FAIL tie_limit got %h exp %h", {match_done, match_winner, round_count}, {1'b1, 2'b00, 4'd9});
        end
    endtask

    task automatic test_new_match_eval();
        pulse_new_match();
        p1_move = 2'b00; p2_move = 2'b10; move_valid = 1'b1;
        @(negedge clk);
        move_valid = 1'b0;
        new_match = 1'b1;
        @(negedge clk);
        new_match = 1'b0;
        checks++;
        if ({round_valid, p1_score, round_count, move_ready} !== {1'b0, 4'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL nm_eval_discard got %h exp %h", {round_valid, p1_score, round_count, move_ready},
                     {1'b0, 4'd0, 4'd0, 1'b1});
        end
        @(negedge clk);
        checks++;
        if (round_valid !== 1'b0 || last_moves !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL nm_eval_after got rv=%b lm=%b exp rv=0 lm=0010", round_valid, last_moves);
        end
    endtask

    task automatic test_ena_freeze();
        bit bad;
        logic [16:0] e;
        p1_move = 2'b01; p2_move = 2'b00; move_valid = 1'b1;
        model_push(1, 0);
        @(negedge clk);
        move_valid = 1'b0;
        ena = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (round_valid !== 1'b0 || move_ready !== 1'b0 || p1_score !== 4'd0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL ena_freeze got rv=%b ready=%b s1=%0d exp 0 0 0", round_valid, move_ready, p1_score);
        end
        ena = 1'b1;
        @(negedge clk);
        e = sb_pop();
        checks++;
        if (round_valid !== 1'b1 || dut_outcome() !== e) begin
            errors++;
            $display("[TB] FAIL ena_resume got rv=%b %h exp rv=1 %h", round_valid, dut_outcome(), e);
        end
        ena = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (round_valid !== 1'b1) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL ena_hold_valid got %b exp 1", round_valid);
        end
        ena = 1'b1;
        @(negedge clk);
        checks++;
        if (round_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ena_valid_clear got %b exp 0", round_valid);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [16:0] e;
        logic [1:0] a, b;
        pulse_new_match();
        for (int i = 0; i < 15; i++) begin
            if (mdone) break;
            a = 2'($urandom_range(0, 3));
            b = 2'($urandom_range(0, 3));
            applyStimulus(a, b, o);
            e = sb_pop();
            checks++;
            if (o.ok !== 1'b1 || o.outcome !== e) begin
                errors++;
                $display("[TB] FAIL rand_round%0d moves %b/%b got %h ok=%b exp %h", i, a, b, o.outcome, o.ok, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; p1_move = '0; p2_move = '0;
        move_valid = 1'b0; new_match = 1'b0;
        m1 = 0; m2 = 0; mrc = 0; mwin = 0; mdone = 0;
        test_reset();
        test_single_round();
        test_invalid();
        test_back_to_back();
        test_ties();
        test_new_match_eval();
        test_ena_freeze();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
